// File: rtl/serial_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_mem_pkg
// Shared types and defaults for the serial memory link sequencer.
//   state_t   : transaction sequencer states (IDLE/ADDR/DATA/DONE)
//   cmd_t     : latched command of the granted requester
//   ADDR_W_DEF / DATA_W_DEF / SYNC_STAGES_DEF : default link geometry
//   CNT_W     : width of the per-phase bit counter
//   arbitrate : fixed-priority pick, write > read > fetch
// ---------------------------------------------------------------------------
package serial_mem_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W           = 5;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    CMD_ROM,
    CMD_RAM_RD,
    CMD_RAM_WR
  } cmd_t;

  // RAM requests are only held mid-instruction, so they outrank fetch to
  // keep the core from deadlocking behind its own instruction stream.
  function automatic cmd_t arbitrate(input logic wr_req, input logic rd_req);
    if (wr_req) begin
      return CMD_RAM_WR;
    end else if (rd_req) begin
      return CMD_RAM_RD;
    end else begin
      return CMD_ROM;
    end
  endfunction

endpackage

// File: rtl/serial_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_mem_ctrl_if
// Core-side request/ack bus of the serial memory sequencer.
//   rom_req/rom_addr        : instruction fetch request (level, held to ack)
//   rom_ack/rom_rdata       : fetch ack pulse and fetched byte
//   ram_rd_req/ram_wr_req   : data RAM read / write requests (level)
//   ram_addr/ram_wdata      : RAM address and write byte
//   ram_ack/ram_rdata       : RAM ack pulse and read byte
//   busy                    : transaction in progress, stalls the core
// Modports: master = CPU side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface serial_mem_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) ();

  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ack;
  logic [DATA_W-1:0] rom_rdata;
  logic              ram_rd_req;
  logic              ram_wr_req;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ack;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport master (
    output rom_req, rom_addr, ram_rd_req, ram_wr_req, ram_addr, ram_wdata,
    input  rom_ack, rom_rdata, ram_ack, ram_rdata, busy
  );

  modport slave (
    input  rom_req, rom_addr, ram_rd_req, ram_wr_req, ram_addr, ram_wdata,
    output rom_ack, rom_rdata, ram_ack, ram_rdata, busy
  );

endinterface

// File: rtl/serial_mem_ctrl_sync_edge.sv
// ---------------------------------------------------------------------------
// serial_sync_edge
// Brings the asynchronous link pins into the clk domain and detects bit
// events.
//   clk, rst        : system clock, synchronous active-high reset
//   sclk_i          : external shift clock (asynchronous)
//   ready_i         : external side ready (asynchronous)
//   serial_in_i     : external read data (asynchronous)
//   serial_in_o     : synchronized serial_in, aligned with bit_event_o
//   bit_event_o     : one-cycle strobe on a synced sclk rise while ready
// STAGES must be at least 2.
// ---------------------------------------------------------------------------
module serial_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic ready_i,
  input  logic serial_in_i,
  output logic serial_in_o,
  output logic bit_event_o
);

  logic [STAGES-1:0] sclk_sync_q;
  logic [STAGES-1:0] ready_sync_q;
  logic [STAGES-1:0] sin_sync_q;
  logic              sclk_prev_q;

  // All three pins share the same depth so serial_in stays aligned with
  // the sclk edge that samples it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q  <= '0;
      ready_sync_q <= '0;
      sin_sync_q   <= '0;
      sclk_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[STAGES-2:0], sclk_i};
      ready_sync_q <= {ready_sync_q[STAGES-2:0], ready_i};
      sin_sync_q   <= {sin_sync_q[STAGES-2:0], serial_in_i};
      sclk_prev_q  <= sclk_sync_q[STAGES-1];
    end
  end

  // A rise seen while ready is low is consumed and never counted later.
  assign bit_event_o = sclk_sync_q[STAGES-1] & ~sclk_prev_q & ready_sync_q[STAGES-1];
  assign serial_in_o = sin_sync_q[STAGES-1];

endmodule

// File: rtl/serial_mem_ctrl.sv
// ---------------------------------------------------------------------------
// serial_mem_ctrl
// Arbitrates the core's ROM fetch and RAM read/write requests and runs one
// serial transaction at a time: ADDR_W address bits, then DATA_W data bits,
// MSB first, one bit per ready-qualified sclk rise.
//   clk, rst        : system clock, synchronous active-high reset
//   bus (slave)     : core request/ack bus, see serial_mem_ctrl_if
//   sclk, ready     : external shift clock and ready (asynchronous)
//   serial_in       : external read data (asynchronous)
//   serial_out      : address / write data to external side
//   addr_phase      : high while the address is being shifted
//   rom_sel, ram_wr_sel, ram_rd_sel : one-hot command flags
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module serial_mem_ctrl
  import serial_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  serial_mem_ctrl_if.slave  bus,
  input  logic              sclk,
  input  logic              ready,
  input  logic              serial_in,
  output logic              serial_out,
  output logic              addr_phase,
  output logic              rom_sel,
  output logic              ram_wr_sel,
  output logic              ram_rd_sel
);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic bit_event;
  logic sin_s;

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_sr_q, addr_sr_d;
  logic [DATA_W-1:0] data_sr_q, data_sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rom_rdata_q, rom_rdata_d;
  logic [DATA_W-1:0] ram_rdata_q, ram_rdata_d;
  logic              rom_ack_q, rom_ack_d;
  logic              ram_ack_q, ram_ack_d;
  logic              busy_q, busy_d;
  logic              serial_out_q, serial_out_d;
  logic              addr_phase_q, addr_phase_d;
  logic              rom_sel_q, rom_sel_d;
  logic              ram_wr_sel_q, ram_wr_sel_d;
  logic              ram_rd_sel_q, ram_rd_sel_d;
  logic              shifting;

  serial_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .sclk_i      (sclk),
    .ready_i     (ready),
    .serial_in_i (serial_in),
    .serial_in_o (sin_s),
    .bit_event_o (bit_event)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= CMD_ROM;
      addr_sr_q    <= '0;
      data_sr_q    <= '0;
      cnt_q        <= '0;
      rom_rdata_q  <= '0;
      ram_rdata_q  <= '0;
      rom_ack_q    <= 1'b0;
      ram_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
      serial_out_q <= 1'b0;
      addr_phase_q <= 1'b0;
      rom_sel_q    <= 1'b0;
      ram_wr_sel_q <= 1'b0;
      ram_rd_sel_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      addr_sr_q    <= addr_sr_d;
      data_sr_q    <= data_sr_d;
      cnt_q        <= cnt_d;
      rom_rdata_q  <= rom_rdata_d;
      ram_rdata_q  <= ram_rdata_d;
      rom_ack_q    <= rom_ack_d;
      ram_ack_q    <= ram_ack_d;
      busy_q       <= busy_d;
      serial_out_q <= serial_out_d;
      addr_phase_q <= addr_phase_d;
      rom_sel_q    <= rom_sel_d;
      ram_wr_sel_q <= ram_wr_sel_d;
      ram_rd_sel_q <= ram_rd_sel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_sr_d   = addr_sr_q;
    data_sr_d   = data_sr_q;
    cnt_d       = cnt_q;
    rom_rdata_d = rom_rdata_q;
    ram_rdata_d = ram_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.ram_wr_req || bus.ram_rd_req || bus.rom_req) begin
          state_d   = ADDR;
          cmd_d     = arbitrate(bus.ram_wr_req, bus.ram_rd_req);
          addr_sr_d = (cmd_d == CMD_ROM) ? bus.rom_addr : bus.ram_addr;
          data_sr_d = (cmd_d == CMD_RAM_WR) ? bus.ram_wdata : '0;
          cnt_d     = '0;
        end
      end

      ADDR: begin
        if (bit_event) begin
          addr_sr_d = {addr_sr_q[ADDR_W-2:0], 1'b0};
          if (cnt_q == ADDR_LAST) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      DATA: begin
        if (bit_event) begin
          // Writes drain the shift register; reads fill it from the LSB.
          if (cmd_q == CMD_RAM_WR) begin
            data_sr_d = {data_sr_q[DATA_W-2:0], 1'b0};
          end else begin
            data_sr_d = {data_sr_q[DATA_W-2:0], sin_s};
          end
          if (cnt_q == DATA_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
            // Capture here so rdata changes on the same edge as the ack.
            if (cmd_q == CMD_ROM) begin
              rom_rdata_d = data_sr_d;
            end else if (cmd_q == CMD_RAM_RD) begin
              ram_rdata_d = data_sr_d;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output flops are loaded from the next-state values so every pin is a
  // plain register while still tracking the state it belongs to.
  always_comb begin
    shifting     = (state_d == ADDR) || (state_d == DATA);
    rom_ack_d    = (state_d == DONE) && (cmd_d == CMD_ROM);
    ram_ack_d    = (state_d == DONE) && (cmd_d != CMD_ROM);
    busy_d       = (state_d != IDLE);
    addr_phase_d = (state_d == ADDR);
    rom_sel_d    = shifting && (cmd_d == CMD_ROM);
    ram_rd_sel_d = shifting && (cmd_d == CMD_RAM_RD);
    ram_wr_sel_d = shifting && (cmd_d == CMD_RAM_WR);
    serial_out_d = 1'b0;
    if (state_d == ADDR) begin
      serial_out_d = addr_sr_d[ADDR_W-1];
    end else if ((state_d == DATA) && (cmd_d == CMD_RAM_WR)) begin
      serial_out_d = data_sr_d[DATA_W-1];
    end
  end

  assign bus.rom_ack   = rom_ack_q;
  assign bus.rom_rdata = rom_rdata_q;
  assign bus.ram_ack   = ram_ack_q;
  assign bus.ram_rdata = ram_rdata_q;
  assign bus.busy      = busy_q;
  assign serial_out    = serial_out_q;
  assign addr_phase    = addr_phase_q;
  assign rom_sel       = rom_sel_q;
  assign ram_wr_sel    = ram_wr_sel_q;
  assign ram_rd_sel    = ram_rd_sel_q;

endmodule

// File: tb/tb_serial_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_mem_ctrl
// Directed bench for serial_mem_ctrl. Acts as both the CPU requester and
// the external serial memory, capturing serial_out before each sclk rise
// and returning read bytes on serial_in MSB first.
// ---------------------------------------------------------------------------
module tb_serial_mem_ctrl;

  localparam int HOLD = 3;

  logic clk = 1'b0;
  logic rst;
  logic sclk;
  logic ready;
  logic serial_in;
  logic serial_out;
  logic addr_phase;
  logic rom_sel;
  logic ram_wr_sel;
  logic ram_rd_sel;

  int assertCount = 0;
  int failCount   = 0;
  int romAckCnt   = 0;
  int ramAckCnt   = 0;
  int overlapCnt  = 0;
  int widthErrCnt = 0;
  logic prevRomAck = 1'b0;
  logic prevRamAck = 1'b0;

  serial_mem_ctrl_if bus ();

  serial_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sclk       (sclk),
    .ready      (ready),
    .serial_in  (serial_in),
    .serial_out (serial_out),
    .addr_phase (addr_phase),
    .rom_sel    (rom_sel),
    .ram_wr_sel (ram_wr_sel),
    .ram_rd_sel (ram_rd_sel)
  );

  always #5 clk = ~clk;

  // Ack counting, ack width and sel one-hot watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.rom_ack) romAckCnt++;
    if (bus.ram_ack) ramAckCnt++;
    if ((bus.rom_ack && prevRomAck) || (bus.ram_ack && prevRamAck)) widthErrCnt++;
    if ((32'(rom_sel) + 32'(ram_rd_sel) + 32'(ram_wr_sel)) > 1) overlapCnt++;
    prevRomAck = bus.rom_ack;
    prevRamAck = bus.ram_ack;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One full sclk pulse with minimum legal high and low times.
  task automatic applyStimulus(input logic bitIn);
    serial_in = bitIn;
    sclk = 1'b1;
    repeat (HOLD) @(negedge clk);
    sclk = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic dropReq(input int reqId);
    case (reqId)
      0: bus.rom_req = 1'b0;
      1: bus.ram_rd_req = 1'b0;
      default: bus.ram_wr_req = 1'b0;
    endcase
  endtask

  // Runs 24 bit events for the request reqId (0 rom, 1 ram rd, 2 ram wr),
  // optionally inserting 5 ready-low pulses before bit gapAt.
  task automatic doTransaction(input int reqId, input logic [7:0] rdByte,
                               input int gapAt, output logic [23:0] outBits,
                               output logic selOk, output logic phaseOk,
                               output int acksBefore, output int acksAfter);
    logic [2:0] expSel;
    logic bitIn;
    int startAcks;
    int waitCnt;
    expSel = (reqId == 0) ? 3'b100 : (reqId == 1) ? 3'b010 : 3'b001;
    startAcks = romAckCnt + ramAckCnt;
    outBits = '0;
    selOk = 1'b1;
    phaseOk = 1'b1;
    acksBefore = 0;
    waitCnt = 0;
    while (!bus.busy && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("grant", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 24; i++) begin
      if (i == gapAt) begin
        ready = 1'b0;
        repeat (HOLD) @(negedge clk);
        repeat (5) applyStimulus(1'b1);
        ready = 1'b1;
        repeat (HOLD) @(negedge clk);
      end
      outBits[23-i] = serial_out;
      if ({rom_sel, ram_rd_sel, ram_wr_sel} != expSel) selOk = 1'b0;
      if (addr_phase != (i < 16)) phaseOk = 1'b0;
      bitIn = (i >= 16) ? rdByte[23-i] : 1'b0;
      if (i < 23) begin
        applyStimulus(bitIn);
        if (i == 22) acksBefore = romAckCnt + ramAckCnt - startAcks;
      end else begin
        serial_in = bitIn;
        sclk = 1'b1;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          if (bus.rom_ack || bus.ram_ack) begin
            dropReq(reqId);
            break;
          end
        end
        sclk = 1'b0;
        repeat (HOLD) @(negedge clk);
      end
    end
    acksAfter = romAckCnt + ramAckCnt - startAcks;
  endtask

  logic [23:0] bits;
  logic selOk, phaseOk;
  int acksBefore, acksAfter, romBase;

  initial begin
    rst = 1'b1;
    sclk = 1'b0;
    ready = 1'b1;
    serial_in = 1'b0;
    bus.rom_req = 1'b0;
    bus.rom_addr = '0;
    bus.ram_rd_req = 1'b0;
    bus.ram_wr_req = 1'b0;
    bus.ram_addr = '0;
    bus.ram_wdata = '0;
    repeat (4) @(negedge clk);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstSel", 32'({rom_sel, ram_rd_sel, ram_wr_sel}), 32'd0);
    checkOutput("rstSout", 32'(serial_out), 32'd0);
    checkOutput("rstRomData", 32'(bus.rom_rdata), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] ROM fetch 0x1234");
    bus.rom_addr = 16'h1234;
    bus.rom_req = 1'b1;
    doTransaction(0, 8'hA5, -1, bits, selOk, phaseOk, acksBefore, acksAfter);
    checkOutput("romBits", 32'(bits), {8'h0, 16'h1234, 8'h00});
    checkOutput("romSel", 32'(selOk), 32'd1);
    checkOutput("romPhase", 32'(phaseOk), 32'd1);
    checkOutput("romNoEarlyAck", 32'(acksBefore), 32'd0);
    checkOutput("romAckOnce", 32'(acksAfter), 32'd1);
    checkOutput("romAckCnt", 32'(romAckCnt), 32'd1);
    checkOutput("romData", 32'(bus.rom_rdata), 32'hA5);

    $display("[TB] RAM write 0x0042 <= 0x3C");
    bus.ram_addr = 16'h0042;
    bus.ram_wdata = 8'h3C;
    bus.ram_wr_req = 1'b1;
    doTransaction(2, 8'hFF, -1, bits, selOk, phaseOk, acksBefore, acksAfter);
    checkOutput("wrBits", 32'(bits), {8'h0, 16'h0042, 8'h3C});
    checkOutput("wrSel", 32'(selOk), 32'd1);
    checkOutput("wrAck", 32'(ramAckCnt), 32'd1);
    checkOutput("wrRamData", 32'(bus.ram_rdata), 32'h00);
    checkOutput("wrRomData", 32'(bus.rom_rdata), 32'hA5);

    $display("[TB] simultaneous write/read/fetch");
    bus.ram_addr = 16'h0100;
    bus.ram_wdata = 8'h99;
    bus.rom_addr = 16'h0300;
    bus.rom_req = 1'b1;
    bus.ram_rd_req = 1'b1;
    bus.ram_wr_req = 1'b1;
    doTransaction(2, 8'h00, -1, bits, selOk, phaseOk, acksBefore, acksAfter);
    checkOutput("triWrBits", 32'(bits), {8'h0, 16'h0100, 8'h99});
    checkOutput("triWrFirst", 32'(selOk), 32'd1);
    doTransaction(1, 8'hC3, -1, bits, selOk, phaseOk, acksBefore, acksAfter);
    checkOutput("triRdBits", 32'(bits), {8'h0, 16'h0100, 8'h00});
    checkOutput("triRdSecond", 32'(selOk), 32'd1);
    checkOutput("triRdData", 32'(bus.ram_rdata), 32'hC3);
    doTransaction(0, 8'h5A, -1, bits, selOk, phaseOk, acksBefore, acksAfter);
    checkOutput("triRomBits", 32'(bits), {8'h0, 16'h0300, 8'h00});
    checkOutput("triRomThird", 32'(selOk), 32'd1);
    checkOutput("triRomData", 32'(bus.rom_rdata), 32'h5A);
    checkOutput("triAcks", 32'(romAckCnt + ramAckCnt), 32'd5);

    $display("[TB] ready low mid-address");
    bus.rom_addr = 16'hA5C3;
    bus.rom_req = 1'b1;
    doTransaction(0, 8'h81, 6, bits, selOk, phaseOk, acksBefore, acksAfter);
    checkOutput("gapBits", 32'(bits), {8'h0, 16'hA5C3, 8'h00});
    checkOutput("gapNoEarlyAck", 32'(acksBefore), 32'd0);
    checkOutput("gapAckOnce", 32'(acksAfter), 32'd1);
    checkOutput("gapData", 32'(bus.rom_rdata), 32'h81);

    $display("[TB] reset after 10 address bits");
    romBase = romAckCnt;
    bus.rom_addr = 16'hFFFF;
    bus.rom_req = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("preRstBusy", 32'(bus.busy), 32'd1);
    repeat (10) applyStimulus(1'b1);
    rst = 1'b1;
    bus.rom_req = 1'b0;
    @(negedge clk);
    checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
    checkOutput("midRstSel", 32'({rom_sel, ram_rd_sel, ram_wr_sel, addr_phase}), 32'd0);
    checkOutput("midRstSout", 32'(serial_out), 32'd0);
    checkOutput("midRstAck", 32'({bus.rom_ack, bus.ram_ack}), 32'd0);
    checkOutput("midRstRomData", 32'(bus.rom_rdata), 32'd0);
    checkOutput("midRstRamData", 32'(bus.ram_rdata), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midRstNoAck", 32'(romAckCnt), 32'(romBase));
    bus.rom_addr = 16'hBEEF;
    bus.rom_req = 1'b1;
    doTransaction(0, 8'h7E, -1, bits, selOk, phaseOk, acksBefore, acksAfter);
    checkOutput("postRstBits", 32'(bits), {8'h0, 16'hBEEF, 8'h00});
    checkOutput("postRstAck", 32'(acksAfter), 32'd1);
    checkOutput("postRstData", 32'(bus.rom_rdata), 32'h7E);

    checkOutput("selOverlap", 32'(overlapCnt), 32'd0);
    checkOutput("ackWidth", 32'(widthErrCnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/serial_mem_ctrl.md
# serial_mem_ctrl

Sequencer for the off-chip serial memory link that backs instruction ROM and data RAM. It arbitrates between the core's ROM fetch port and RAM read/write port and runs one serial transaction at a time over sclk/ready/serial_in/serial_out: a 16-bit address phase, then an 8-bit data phase. It acks the winning requester with read data, and stalls the core in the meantime. It sits between the CPU datapath (pc, mar, databus) and the top-level ui_in/uo_out pins.

## Interface
- ADDR_W, 16, address bits shifted per transaction
- DATA_W, 8, data bits shifted per transaction
- SYNC_STAGES, 2, synchronizer depth on sclk, ready, serial_in (min 2)

- clk  in  1  system clock; one clock domain, all state on rising edge
- rst  in  1  synchronous, active-high reset
- rom_req  in  1  level; fetch requested, held until rom_ack
- rom_addr  in  ADDR_W  fetch address (pc); stable while rom_req
- rom_ack  out  1  one-cycle pulse; rom_rdata valid this cycle
- rom_rdata  out  DATA_W  fetched byte; holds until next ack
- ram_rd_req / ram_wr_req  in  1  level; held until ram_ack
- ram_addr  in  ADDR_W  zero-extended mar; stable while request
- ram_wdata  in  DATA_W  write byte; stable while ram_wr_req
- ram_ack  out  1  one-cycle pulse; ram_rdata valid on reads
- ram_rdata  out  DATA_W  read byte; holds until next ack
- busy  out  1  transaction in progress (core stall)
- sclk  in  1  external shift clock, asynchronous
- ready  in  1  external side ready; edges ignored while low
- serial_in  in  1  read data from external side, MSB first
- serial_out  out  1  address/write data to external side, MSB first
- addr_phase  out  1  high during address phase
- rom_sel / ram_wr_sel / ram_rd_sel  out  1  one-hot command flags, high for the whole transaction

## Operation
- sclk, ready, serial_in each pass SYNC_STAGES flops; bit event = synced sclk rising (synced sclk high, previous synced sclk low) AND synced ready high.
- States: IDLE -> ADDR -> DATA -> DONE -> IDLE.
- IDLE: busy=0, all sel=0, serial_out=0. If any request is present, grant, latch addr/wdata/command, go ADDR.
- Priority: ram_wr_req > ram_rd_req > rom_req. The core holds RAM requests only mid-instruction, so RAM must not starve behind fetch. Simultaneous rd+wr: write served, read stays pending.
- ADDR: serial_out = current address MSB; each bit event shifts left one. After ADDR_W events go to DATA.
- DATA write: serial_out = wdata MSB on entry; each event shifts. DATA read: each event shifts synced serial_in into a shift register LSB; serial_out=0. After DATA_W events go to DONE.
- DONE (one cycle): pulse the granted ack, update the matching rdata register (reads only), sel low, go IDLE. Requests may be re-evaluated on the following cycle.
- Bit counter is 5 bits, reloaded on each phase entry; no wrap.
- Request deasserted mid-transaction: the transaction completes and acks anyway (requesters must not drop).
- Synchronous rst at any point: IDLE, counters 0, serial_out 0, sel/addr_phase/busy 0, no ack, rdata registers 0. A partial transaction is abandoned; the external side resynchronises on the sel falling.

## Timing
- Request to sel/busy high: 1 clk (registered grant).
- Bit event latency: SYNC_STAGES+1 clk after the physical sclk rise. serial_out updates on the clk of the event. sclk high and low must each last ≥ SYNC_STAGES+1 clk.
- serial_in is sampled on the same synced edge, so it must be stable around the sclk rise.
- Transaction = ADDR_W+DATA_W bit events + 1 DONE cycle. Back-to-back grants are separated by ≥1 IDLE cycle.
- All outputs are registered. Ack is exactly 1 clk wide.

## Structure
- Shared package serial_mem_pkg: state enum (IDLE/ADDR/DATA/DONE), command enum (CMD_ROM/CMD_RAM_RD/CMD_RAM_WR), default ADDR_W/DATA_W.
- One sub-module: serial_sync_edge (N-stage synchronizer for sclk/ready/serial_in, plus the rising-edge/event output). Arbiter, FSM and shifters stay in the top.

## Test plan
- rom_req, rom_addr=16'h1234; external model returns 8'hA5 → serial_out address bits 0001_0010_0011_0100; rom_ack single pulse after 24 events; rom_rdata=8'hA5.
- ram_wr_req, ram_addr=16'h0042, ram_wdata=8'h3C → 24 bits 0x0042 then 0x3C observed with ram_wr_sel high throughout; ram_ack pulse; ram_rdata unchanged.
- rom_req, ram_rd_req and ram_wr_req all asserted the same cycle → order write, read, fetch; three acks; one-hot sel never overlaps.
- ready low for 5 sclk pulses mid-ADDR → those pulses are not counted; ack still arrives after exactly 24 ready-qualified events.
- rst asserted after 10 address bits → next clk: busy=0, sel=0, serial_out=0, no ack; a new rom_req afterwards completes normally from bit 15.
- sclk high/low of exactly SYNC_STAGES+1 clk → no missed or double-counted events.
